// File: rtl/freq_counter_pkg.sv
// freq_counter_pkg
// Shared definitions for the multi-channel frequency counter:
//   - default parameter values for freq_counter_mc
//   - gate FSM state type (idle / gate open)
//   - result emitter state type (nothing to send / draining shadows)
//   - ch_width(): width of a channel index, never less than one bit
package freq_counter_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 16;
  localparam int DEF_GATE_W = 24;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GATE = 1'b1
  } gate_state_e;

  typedef enum logic {
    EM_EMPTY = 1'b0,
    EM_SEND  = 1'b1
  } emit_state_e;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// edge_sync
// One-bit input conditioner: a two-flop synchroniser followed by a
// rising-edge detector. A pin that rises during clock cycle p shows up as
// a one-cycle sig_edge pulse in the cycle after the second rising clock
// edge, so a counter fed from sig_edge updates on the third clock edge.
// Ports:
//   clk      in  system clock, rising edge
//   rst      in  asynchronous active-high reset
//   sig_in   in  asynchronous input bit
//   sig_edge out one-cycle pulse per synchronised rising edge
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic sig_edge
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = sig_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign sig_edge = sync2_q & ~prev_q;

endmodule

// File: rtl/freq_counter_mc.sv
// freq_counter_mc
// Multi-channel gated frequency counter. A start pulse opens a gate of
// max(gate_cycles,1) clock cycles during which synchronised rising edges
// on every sig_in bit are counted (saturating). At gate end the counts are
// copied to shadow registers and streamed out one channel per handshake.
// In continuous mode the gate re-arms immediately. A gate ending while the
// previous results are still draining drops its snapshot and pulses overrun.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   sig_in       NUM_CH measured signals (asynchronous)
//   gate_cycles  gate length, sampled when a gate starts
//   start        one-cycle measurement request (ignored while gating)
//   cont         re-arm the gate after each gate end
//   busy         gate open or results still undelivered
//   res_valid / res_ready / res_ch / res_count   result stream
//   overrun      one-cycle pulse when a snapshot is dropped
//   res_ovf      (FREQ_COUNTER_MC_OVF_EN only) result's counter saturated
// Build option: define FREQ_COUNTER_MC_OVF_EN to add res_ovf.
module freq_counter_mc
  import freq_counter_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int GATE_W = DEF_GATE_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             sig_in,
  input  logic [GATE_W-1:0]             gate_cycles,
  input  logic                          start,
  input  logic                          cont,
  output logic                          busy,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [ch_width(NUM_CH)-1:0]   res_ch,
  output logic [CNT_W-1:0]              res_count,
  output logic                          overrun
`ifdef FREQ_COUNTER_MC_OVF_EN
  ,
  output logic                          res_ovf
`endif
);

  localparam int               CH_W    = ch_width(NUM_CH);
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0] edge_det;

  gate_state_e       state_q, state_d;
  logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
  logic [GATE_W-1:0] gate_load;
  logic              gate_end;
  logic              clear_cnt;

  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [CNT_W-1:0]  cnt_next [NUM_CH];
  logic [CNT_W-1:0]  shadow_q [NUM_CH];
  logic [CNT_W-1:0]  shadow_d [NUM_CH];

  emit_state_e       em_q, em_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              overrun_q, overrun_d;

`ifdef FREQ_COUNTER_MC_OVF_EN
  logic [NUM_CH-1:0] sat_q, sat_d, sat_next;
  logic [NUM_CH-1:0] shadow_ovf_q, shadow_ovf_d;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_sync
    edge_sync u_edge_sync (
      .clk      (clk),
      .rst      (rst),
      .sig_in   (sig_in[i]),
      .sig_edge (edge_det[i])
    );
  end

  // A zero gate length still opens a one-cycle gate.
  assign gate_load = (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;

  // Gate FSM. gate_cnt_q holds the cycles left including the current one,
  // so the gate ends in the cycle where it reads 1. Continuous mode reloads
  // and clears the counters in that same cycle so no gate cycle is lost.
  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    gate_end   = 1'b0;
    clear_cnt  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_GATE;
          gate_cnt_d = gate_load;
          clear_cnt  = 1'b1;
        end
      end
      ST_GATE: begin
        if (gate_cnt_q == GATE_W'(1)) begin
          gate_end = 1'b1;
          if (cont) begin
            gate_cnt_d = gate_load;
            clear_cnt  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gate_cnt_d = gate_cnt_q - GATE_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // cnt_next includes the edge seen this cycle, which is what the snapshot
  // captures so an edge in the final gate cycle is not lost.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_next[i] = cnt_q[i];
      if ((state_q == ST_GATE) && edge_det[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_next[i] = cnt_q[i] + CNT_W'(1);
      end
      cnt_d[i] = clear_cnt ? '0 : cnt_next[i];
    end
  end

`ifdef FREQ_COUNTER_MC_OVF_EN
  // The flag marks a gate in which at least one edge arrived while the
  // counter was already pinned at all-ones, i.e. the true count was lost.
  always_comb begin
    sat_next = sat_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if ((state_q == ST_GATE) && edge_det[i] && (cnt_q[i] == CNT_MAX)) begin
        sat_next[i] = 1'b1;
      end
    end
    sat_d = clear_cnt ? '0 : sat_next;
  end
`endif

  // Result emitter. Shadows only load when the previous snapshot has been
  // fully accepted; a gate end during a drain (even on the final handshake
  // cycle) drops the new snapshot instead.
  always_comb begin
    em_d      = em_q;
    ch_d      = ch_q;
    shadow_d  = shadow_q;
    overrun_d = 1'b0;
`ifdef FREQ_COUNTER_MC_OVF_EN
    shadow_ovf_d = shadow_ovf_q;
`endif
    if ((em_q == EM_SEND) && res_ready) begin
      if (ch_q == LAST_CH) begin
        em_d = EM_EMPTY;
        ch_d = '0;
      end else begin
        ch_d = ch_q + CH_W'(1);
      end
    end
    if (gate_end) begin
      if (em_q == EM_EMPTY) begin
        shadow_d = cnt_next;
        em_d     = EM_SEND;
        ch_d     = '0;
`ifdef FREQ_COUNTER_MC_OVF_EN
        shadow_ovf_d = sat_next;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gate_cnt_q <= '0;
      em_q       <= EM_EMPTY;
      ch_q       <= '0;
      overrun_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
`ifdef FREQ_COUNTER_MC_OVF_EN
      sat_q        <= '0;
      shadow_ovf_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      em_q       <= em_d;
      ch_q       <= ch_d;
      overrun_q  <= overrun_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= cnt_d[i];
        shadow_q[i] <= shadow_d[i];
      end
`ifdef FREQ_COUNTER_MC_OVF_EN
      sat_q        <= sat_d;
      shadow_ovf_q <= shadow_ovf_d;
`endif
    end
  end

  assign res_valid = (em_q == EM_SEND);
  assign res_ch    = ch_q;
  assign res_count = res_valid ? shadow_q[ch_q] : '0;
  assign overrun   = overrun_q;
  assign busy      = (state_q != ST_IDLE) || (em_q == EM_SEND);

`ifdef FREQ_COUNTER_MC_OVF_EN
  assign res_ovf = res_valid & shadow_ovf_q[ch_q];
`endif

endmodule

// File: tb/tb_freq_counter_mc.sv
// tb_freq_counter_mc
// Randomised scoreboard bench for freq_counter_mc (NUM_CH=4, CNT_W=4).
// The reference model works from pin samples: a rising pin is counted three
// clock edges later if a gate is open then; each gate keeps the true number
// of edges per channel and reports min(true, 15). Expected result words go
// into a queue at gate end; a negedge monitor pops and compares them.
// Compiles with or without FREQ_COUNTER_MC_OVF_EN.
module tb_freq_counter_mc;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 4;
  localparam int GATE_W  = 24;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] sig_in;
  logic [GATE_W-1:0] gate_cycles;
  logic              start;
  logic              cont;
  logic              busy;
  logic              res_valid;
  logic              res_ready;
  logic [1:0]        res_ch;
  logic [CNT_W-1:0]  res_count;
  logic              overrun;
`ifdef FREQ_COUNTER_MC_OVF_EN
  logic              res_ovf;
`endif

  always #5 clk = ~clk;

  freq_counter_mc #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .GATE_W (GATE_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sig_in      (sig_in),
    .gate_cycles (gate_cycles),
    .start       (start),
    .cont        (cont),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_ch      (res_ch),
    .res_count   (res_count),
    .overrun     (overrun)
`ifdef FREQ_COUNTER_MC_OVF_EN
    ,
    .res_ovf     (res_ovf)
`endif
  );

  typedef struct {
    int ch;
    int count;
    bit ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state
  bit                m_gating;
  int                m_left;
  int                m_true [NUM_CH];
  int                m_pending;
  bit                m_ovr;
  logic [NUM_CH-1:0] hist1, hist2, hist3;
  logic [NUM_CH-1:0] m_edges;
  int                pend_pre;
  exp_t              m_e;

  // Stimulus mode state
  int sig_mode;
  int ready_mode;
  int ph;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Behavioural model, advanced once per rising clock edge.
  initial begin
    m_gating  = 1'b0;
    m_left    = 0;
    m_pending = 0;
    m_ovr     = 1'b0;
    hist1 = '0; hist2 = '0; hist3 = '0;
    for (int i = 0; i < NUM_CH; i++) m_true[i] = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_gating  = 1'b0;
        m_left    = 0;
        m_pending = 0;
        m_ovr     = 1'b0;
        hist1 = '0; hist2 = '0; hist3 = '0;
        for (int i = 0; i < NUM_CH; i++) m_true[i] = 0;
        exp_q.delete();
      end else begin
        m_edges  = hist2 & ~hist3;
        pend_pre = m_pending;
        m_ovr    = 1'b0;
        if (m_gating) begin
          for (int i = 0; i < NUM_CH; i++) if (m_edges[i]) m_true[i]++;
          m_left--;
          if (m_left == 0) begin
            if (pend_pre == 0) begin
              for (int i = 0; i < NUM_CH; i++) begin
                m_e.ch    = i;
                m_e.count = (m_true[i] > CNT_MAX) ? CNT_MAX : m_true[i];
                m_e.ovf   = (m_true[i] > CNT_MAX);
                exp_q.push_back(m_e);
              end
            end else begin
              m_ovr = 1'b1;
            end
            if (cont) begin
              m_left = (gate_cycles == 0) ? 1 : int'(gate_cycles);
              for (int i = 0; i < NUM_CH; i++) m_true[i] = 0;
            end else begin
              m_gating = 1'b0;
            end
          end
        end else if (start) begin
          m_gating = 1'b1;
          m_left   = (gate_cycles == 0) ? 1 : int'(gate_cycles);
          for (int i = 0; i < NUM_CH; i++) m_true[i] = 0;
        end
        if ((pend_pre > 0) && res_ready) m_pending--;
        if ((pend_pre == 0) && m_gating === 1'b1 && m_left == 0) m_pending = m_pending;
        if (exp_q.size() > m_pending && pend_pre == 0 && exp_q.size() == NUM_CH) m_pending = NUM_CH;
        hist3 = hist2;
        hist2 = hist1;
        hist1 = sig_in;
      end
    end
  end

  // Monitor: compares outputs against the model on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        checkOutput("reset_outputs", {busy, res_valid, res_ch, res_count, overrun}, 0);
`ifdef FREQ_COUNTER_MC_OVF_EN
        checkOutput("reset_res_ovf", res_ovf, 0);
`endif
      end else begin
        checkOutput("busy", busy, (m_gating || (m_pending > 0)) ? 1 : 0);
        checkOutput("overrun", overrun, m_ovr);
        checkOutput("res_valid", res_valid, (m_pending > 0) ? 1 : 0);
        if (res_valid) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_result", 1, 0);
          end else begin
            checkOutput("res_ch", res_ch, exp_q[0].ch);
            checkOutput("res_count", res_count, exp_q[0].count);
`ifdef FREQ_COUNTER_MC_OVF_EN
            checkOutput("res_ovf", res_ovf, exp_q[0].ovf);
`endif
            if (res_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // Advance n cycles, updating inputs just after each rising edge.
  task automatic step(input int n);
    logic [NUM_CH-1:0] tmp;
    repeat (n) begin
      @(posedge clk);
      #1;
      ph++;
      case (sig_mode)
        1: begin
          tmp    = '0;
          tmp[0] = ((ph % 10) >= 5);
          sig_in = tmp;
        end
        2: sig_in = NUM_CH'($urandom);
        3: begin
          tmp    = '0;
          tmp[1] = ~sig_in[1];
          sig_in = tmp;
        end
        default: ;
      endcase
      case (ready_mode)
        0:       res_ready = 1'b0;
        1:       res_ready = 1'b1;
        default: res_ready = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic applyStimulus(input int gc, input bit c, input int smode, input int rmode);
    gate_cycles = GATE_W'(gc);
    cont        = c;
    sig_mode    = smode;
    ready_mode  = rmode;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n = 0;
    while (busy && (n < limit)) begin
      step(1);
      n++;
    end
    checkOutput(name, busy, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    sig_in      = '0;
    gate_cycles = '0;
    start       = 1'b0;
    cont        = 1'b0;
    res_ready   = 1'b0;
    sig_mode    = 0;
    ready_mode  = 0;
    ph          = 0;
    step(3);
    rst = 1'b0;
    step(2);
    checkOutput("idle_after_reset", {busy, res_valid, overrun}, 0);

    // 100-cycle gate, ch0 with period 10, consumer always ready
    applyStimulus(100, 1'b0, 1, 1);
    pulse_start();
    wait_idle(400, "busy_fall_period10");

    // zero gate length, single edge on ch2 landing in the one gate cycle
    applyStimulus(0, 1'b0, 0, 1);
    sig_in = '0;
    step(4);
    sig_in[2] = 1'b1;
    step(1);
    pulse_start();
    step(3);
    sig_in = '0;
    wait_idle(50, "busy_fall_zero_gate");

    // continuous gates with a stalled consumer: overruns, held first snapshot
    applyStimulus(20, 1'b1, 2, 0);
    pulse_start();
    step(90);
    cont = 1'b0;
    step(25);
    ready_mode = 1;
    wait_idle(100, "busy_fall_overrun");

    // saturation: 40 edges on ch1 in an 80-cycle gate
    applyStimulus(80, 1'b0, 3, 1);
    pulse_start();
    wait_idle(200, "busy_fall_saturate");
    sig_mode = 0;
    sig_in   = '0;

    // random gates, random cont and random ready
    for (int it = 0; it < 8; it++) begin
      applyStimulus(int'($urandom_range(0, 30)), 1'($urandom_range(0, 1)), 2, 2);
      pulse_start();
      step(int'($urandom_range(5, 60)));
    end
    cont       = 1'b0;
    ready_mode = 1;
    wait_idle(500, "busy_fall_random");

    // reset in the middle of a gate
    applyStimulus(50, 1'b0, 2, 1);
    pulse_start();
    step(20);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(30);
    checkOutput("idle_after_gate_reset", {busy, res_valid}, 0);

    // reset in the middle of a drain
    applyStimulus(5, 1'b0, 2, 0);
    pulse_start();
    step(10);
    checkOutput("drain_pending_valid", res_valid, 1);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    ready_mode = 1;
    step(20);
    checkOutput("idle_after_drain_reset", {busy, res_valid}, 0);

    sig_mode = 0;
    sig_in   = '0;
    wait_idle(100, "busy_fall_final");
    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freq_counter_mc.md
FREQ_COUNTER_MC -- requirements
Module: freq_counter_mc

Interface
REQ-001 Parameter NUM_CH, default 4, number of measured input channels (1..8).
REQ-002 Parameter CNT_W, default 16, width of per-channel edge counter and result.
REQ-003 Parameter GATE_W, default 24, width of gate-length value.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  system clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 sig_in  input  NUM_CH  asynchronous signals to be measured.
REQ-008 gate_cycles  input  GATE_W  gate length in clk cycles, sampled at gate start.
REQ-009 start  input  1  single-cycle request to begin a measurement.
REQ-010 cont  input  1  continuous mode: re-arm gate automatically after each gate.
REQ-011 busy  output  1  high while a gate is open or results remain undelivered.
REQ-012 res_valid  output  1  result word available.
REQ-013 res_ready  input  1  consumer accepts result when res_valid and res_ready both high.
REQ-014 res_ch  output  $clog2(NUM_CH) (min 1)  channel index of result.
REQ-015 res_count  output  CNT_W  rising edges counted in the gate for res_ch.
REQ-016 overrun  output  1  one-cycle pulse when a snapshot is dropped.

Function
REQ-017 Each sig_in bit passes a 2-flop synchroniser, then a rising-edge detector; edge counted 3 clk cycles after pin transition.
REQ-018 Gate FSM states: IDLE, GATE; drain tracked by independent result-emitter state (EMPTY, SEND).
REQ-019 IDLE->GATE on start; gate counter loaded with max(gate_cycles,1); edge counters cleared same cycle.
REQ-020 GATE lasts exactly the loaded number of cycles; an edge detected in the final gate cycle is counted.
REQ-021 Gate end: all edge counters copied to shadow registers in the same cycle; emitter EMPTY->SEND.
REQ-022 Gate end with cont high: next gate starts next cycle (no lost cycle beyond one), gate_cycles re-sampled; cont low: return to IDLE.
REQ-023 start while in GATE ignored; start in IDLE while emitter in SEND accepted.
REQ-024 Emitter in SEND presents channels 0..NUM_CH-1 in order; res_ch/res_count stable while res_valid and not res_ready.
REQ-025 Advance to next channel only on handshake; after channel NUM_CH-1 accepted, SEND->EMPTY.
REQ-026 Gate end while emitter in SEND: new snapshot discarded, shadows unchanged, overrun pulses one cycle.
REQ-027 Edge counters saturate at all-ones; never wrap.
REQ-028 busy = (FSM != IDLE) or (emitter == SEND).

Reset
REQ-029 rst asserted: FSM IDLE, emitter EMPTY, all counters, shadows and synchronisers zero.
REQ-030 Outputs during/after reset: busy 0, res_valid 0, res_ch 0, res_count 0, overrun 0.
REQ-031 Reset mid-gate or mid-drain discards all pending results; no partial result emitted after release.

Configuration
REQ-032 Macro FREQ_COUNTER_MC_OVF_EN: when defined, output res_ovf (1 bit) added, high with a result whose counter saturated during its gate, reset 0.
REQ-033 Without FREQ_COUNTER_MC_OVF_EN: no res_ovf port, no saturation-flag storage; counting still saturates.

Structure
REQ-034 Shared package freq_counter_pkg holds FSM state enum, emitter state enum, and default parameter constants.
REQ-035 One sub-module edge_sync (2-flop synchroniser plus rising-edge detect, one bit) instantiated NUM_CH times.

Verification
REQ-036 gate_cycles=100, sig_in[0] toggling period 10 clk, start pulse, res_ready=1 -> results ch0=10 (±1), ch1..3=0, busy falls after ch3 accepted.
REQ-037 gate_cycles=0, one edge on ch2 inside gate -> gate lasts 1 cycle; ch2 result 0 or 1 consistent with REQ-017/020 timing model.
REQ-038 cont=1, gate_cycles=20, res_ready=0 -> first snapshot held at ch0, overrun pulses at each later gate end, counts unchanged when ready released.
REQ-039 CNT_W=4, 40 edges in gate -> res_count=15; with FREQ_COUNTER_MC_OVF_EN res_ovf=1, other channels res_ovf=0.
REQ-040 res_ready toggled randomly during drain -> no channel skipped or duplicated; fields stable while stalled.
REQ-041 rst asserted mid-gate and mid-drain -> all outputs 0 within reset; after release no result until new start.
